demux8_deser: RTL
=================

Name: demux8_deser

Overview:
Serial-to-parallel demultiplexer. It is the write-side counterpart of mux8: mux8 selects bit D[sel] onto Y, while this block steers one serial bit per accepted beat into word position sel. A 3-bit position counter drives sel. Completed words are held in an output register with a valid/ready handshake. The block sits wherever a one-bit stream must be rebuilt into the 8-bit word that a mux8 scan (sel = 0..7) would emit.

Parameters:
W, 8, word width; power of two, at least 2; counter width SW = $clog2(W)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
din  input  1  serial data bit
din_valid  input  1  din is accepted this cycle
clr  input  1  synchronous abort of the partial word; also clears overflow
sel  output  SW  position the next accepted bit will occupy
Y  output  W  completed word
Y_valid  output  1  Y holds an unconsumed word
Y_ready  input  1  consumer accepts Y when Y_valid && Y_ready
overflow  output  1  sticky: a completed word was dropped
parity_err  output  1  parity result for the word in Y (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): sel=0, shadow=0, Y=0, Y_valid=0, overflow=0, parity_err=0, FSM=IDLE.
- FSM states:
  - IDLE: sel==0, no partial word. Moves to FILL on an accepted bit.
  - FILL: partial word in progress. Returns to IDLE on the completing bit or on clr.
  - PAR: exists only with the macro defined; see Optional Feature.
- Accepted bit (din_valid=1, clr=0): shadow[sel] <= din, then sel <= sel+1. Bit 0 is the first bit received (LSB first). sel wraps from W-1 to 0.
- Cycles with din_valid=0: hold all state. Gaps between bits are unlimited.
- Completion: the accepted bit at sel==W-1 (macro off) completes the word.
  - Loading the word: {din, shadow[W-2:0]} goes to Y and Y_valid rises on the next clock edge (latency 1 cycle after the last bit).
  - The load happens only if Y_valid==0, or if Y_valid && Y_ready in the same cycle (back-to-back replacement; Y_valid stays 1).
  - If Y_valid==1 and Y_ready==0: the new word is dropped, Y is kept, overflow <= 1.
  - sel returns to 0 in all three cases.
- Handshake: Y_valid && Y_ready with no completion in that cycle gives Y_valid <= 0 on the next edge. Y keeps its last value; it is not cleared. Y and parity_err are stable while Y_valid is 1.
- clr: sel <= 0, shadow <= 0, overflow <= 0, FSM <= IDLE.
  - clr wins over din_valid in the same cycle; that bit is discarded.
  - Y, Y_valid and parity_err are not affected by clr.
- Reset mid-word: the partial word is lost and all outputs return to their reset values immediately.

Optional Feature:
Macro DEMUX8_PARITY_EN.
- Defined: each frame is W data bits followed by one even-parity bit.
  - After data bit W-1, the FSM enters PAR, with sel held at W-1.
  - The next accepted bit completes the word. Completion, drop and overflow rules are the same as above, applied to this bit.
  - parity_err = XOR(data bits, parity bit), registered together with Y.
  - clr in PAR aborts the frame.
- Not defined: there is no PAR state, a frame is exactly W bits, and parity_err is constant 0.

Test Plan:
1. Bits 1,0,0,1,0,1,1,0 on 8 consecutive cycles, Y_ready=1 -> Y=8'h69 and Y_valid=1 one cycle after the 8th bit; sel reads 0..7 during the beats and 0 afterwards.
2. Same stream with din_valid idle for 3 cycles between bits 3 and 4 -> identical Y=8'h69; sel holds at 4 during the gap.
3. Y_ready=0, send 8'h69 then 8'hA5 -> Y stays 8'h69, overflow=1. Raise Y_ready -> Y_valid falls. Pulse clr -> overflow=0.
4. Y_valid=1 with 8'h69; the last bit of 8'h3C arrives in the same cycle as Y_ready=1 -> Y=8'h3C next cycle, Y_valid stays 1, overflow=0.
5. Send 4 bits, pulse clr together with a bit, then send 8'hF0 -> Y=8'hF0. Separately, drop rst_n after 5 bits -> sel=0, Y_valid=0 without waiting for a clock edge.
6. With DEMUX8_PARITY_EN: frame 8'h69 plus parity 0 -> parity_err=0; frame 8'h69 plus parity 1 -> parity_err=1. Without the macro: parity_err is 0 throughout.

Source files
------------

// File: rtl/demux8_deser_if.sv
// Stream-side and word-side signals of the demux8_deser serial-to-parallel block.
// master drives the serial stream and consumes words; slave is the deserializer.
interface demux8_deser_if #(
    parameter int W = 8
) ();
    localparam int SW = $clog2(W);

    logic          din;
    logic          din_valid;
    logic          clr;
    logic [SW-1:0] sel;
    logic [W-1:0]  Y;
    logic          Y_valid;
    logic          Y_ready;
    logic          overflow;
    logic          parity_err;

    modport master (
        output din,
        output din_valid,
        output clr,
        output Y_ready,
        input  sel,
        input  Y,
        input  Y_valid,
        input  overflow,
        input  parity_err
    );

    modport slave (
        input  din,
        input  din_valid,
        input  clr,
        input  Y_ready,
        output sel,
        output Y,
        output Y_valid,
        output overflow,
        output parity_err
    );
endinterface

// File: rtl/demux8_deser.sv
// Serial-to-parallel demultiplexer: steers one accepted bit per beat into word position sel (LSB first).
// Optional even-parity trailer bit per frame when DEMUX8_PARITY_EN is defined.
module demux8_deser #(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    demux8_deser_if.slave bus
);
    localparam int SW = $clog2(W);
    localparam logic [SW-1:0] SEL_LAST = SW'(W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
`ifdef DEMUX8_PARITY_EN
    localparam logic [1:0] ST_PAR  = 2'd2;
`endif

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [W-1:0]  shadow_q, shadow_d;
    logic [W-1:0]  y_q, y_d;
    logic          y_valid_q, y_valid_d;
    logic          overflow_q, overflow_d;
`ifdef DEMUX8_PARITY_EN
    logic          parity_err_q, parity_err_d;
    logic          parity_c;
`endif

    logic          complete;
    logic          load;
    logic          drop;
    logic [W-1:0]  word_c;

    // Frame assembly: position counter, shadow word and completion detection.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        complete = 1'b0;
        word_c   = shadow_q;
`ifdef DEMUX8_PARITY_EN
        parity_c = 1'b0;
`endif
        if (bus.clr) begin
            state_d  = ST_IDLE;
            sel_d    = '0;
            shadow_d = '0;
        end else if (bus.din_valid) begin
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    shadow_d[sel_q] = bus.din;
                    if (sel_q == SEL_LAST) begin
`ifdef DEMUX8_PARITY_EN
                        // Last data bit stored; sel parks at W-1 until the parity bit arrives.
                        state_d = ST_PAR;
`else
                        complete = 1'b1;
                        word_c   = {bus.din, shadow_q[W-2:0]};
                        state_d  = ST_IDLE;
                        sel_d    = '0;
`endif
                    end else begin
                        state_d = ST_FILL;
                        sel_d   = sel_q + SW'(1);
                    end
                end
`ifdef DEMUX8_PARITY_EN
                ST_PAR: begin
                    complete = 1'b1;
                    word_c   = shadow_q;
                    parity_c = ^{shadow_q, bus.din};
                    state_d  = ST_IDLE;
                    sel_d    = '0;
                end
`endif
                default: begin
                    state_d  = ST_IDLE;
                    sel_d    = '0;
                    shadow_d = '0;
                end
            endcase
        end
    end

    // Output word register: load when free or being consumed this cycle, otherwise drop and flag.
    always_comb begin
        load       = complete && (!y_valid_q || bus.Y_ready);
        drop       = complete && y_valid_q && !bus.Y_ready;
        y_d        = y_q;
        y_valid_d  = y_valid_q;
        overflow_d = overflow_q;
`ifdef DEMUX8_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (load) begin
            y_d       = word_c;
            y_valid_d = 1'b1;
`ifdef DEMUX8_PARITY_EN
            parity_err_d = parity_c;
`endif
        end else if (y_valid_q && bus.Y_ready) begin
            y_valid_d = 1'b0;
        end
        if (bus.clr) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            // NOTE: shadow is a small flop bank, not a RAM, so it is reset with everything else.
            shadow_q   <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifdef DEMUX8_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates, so every flop samples the pre-edge values.
            state_q    <= state_d;
            sel_q      <= sel_d;
            shadow_q   <= shadow_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            overflow_q <= overflow_d;
`ifdef DEMUX8_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.sel      = sel_q;
    assign bus.Y        = y_q;
    assign bus.Y_valid  = y_valid_q;
    assign bus.overflow = overflow_q;
`ifdef DEMUX8_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
